// File: rtl/muldiv_sched_if.sv
// Request/response bundle between the issue slots, the M-extension scheduler
// and writeback.
//   master : issue + writeback side. Drives the requests and resp_ready.
//   slave  : scheduler side. Drives the request readies and the tagged result.
// Handshake: a request or response transfers on a rising edge where its
// valid and ready are both high. A request holds its payload while it is not
// yet accepted. The scheduler holds resp_* stable while resp_valid=1 and
// resp_ready=0.
interface muldiv_sched_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             req_a_valid;
    logic [4:0]       req_a_op;
    logic [XLEN-1:0]  req_a_rs1;
    logic [XLEN-1:0]  req_a_rs2;
    logic [TAG_W-1:0] req_a_tag;
    logic             req_a_ready;
    logic             req_b_valid;
    logic [4:0]       req_b_op;
    logic [XLEN-1:0]  req_b_rs1;
    logic [XLEN-1:0]  req_b_rs2;
    logic [TAG_W-1:0] req_b_tag;
    logic             req_b_ready;
    logic             resp_valid;
    logic             resp_ready;
    logic [XLEN-1:0]  resp_data;
    logic [TAG_W-1:0] resp_tag;
    logic             resp_src;

    modport master (
        output req_a_valid, req_a_op, req_a_rs1, req_a_rs2, req_a_tag,
        output req_b_valid, req_b_op, req_b_rs1, req_b_rs2, req_b_tag,
        output resp_ready,
        input  req_a_ready, req_b_ready,
        input  resp_valid, resp_data, resp_tag, resp_src
    );

    modport slave (
        input  req_a_valid, req_a_op, req_a_rs1, req_a_rs2, req_a_tag,
        input  req_b_valid, req_b_op, req_b_rs1, req_b_rs2, req_b_tag,
        input  resp_ready,
        output req_a_ready, req_b_ready,
        output resp_valid, resp_data, resp_tag, resp_src
    );
endinterface

// File: rtl/muldiv_sched.sv
// Shared mul/div/rem scheduler for the two issue slots. It runs one op at a
// time: a fixed-latency multiply, or a radix-2 restoring divide that takes one
// iteration per cycle. The tagged result is returned over the resp handshake.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   flush       synchronous abort of the in-flight op or the pending response
//   bus         slave side of muldiv_sched_if (slot A/B requests, response)
//   busy        high whenever the FSM is not IDLE
//   dbg_state   current FSM state (0 IDLE, 1 MUL, 2 DIV, 3 RESP)
module muldiv_sched #(
    parameter int XLEN    = 32,
    parameter int TAG_W   = 5,
    parameter int MUL_LAT = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    muldiv_sched_if.slave bus,
    output logic          busy,
    output logic [1:0]    dbg_state
);
    localparam logic [4:0] OP_MUL    = 5'b10110;
    localparam logic [4:0] OP_MULH   = 5'b10010;
    localparam logic [4:0] OP_MULHSU = 5'b10001;
    localparam logic [4:0] OP_MULHU  = 5'b10000;
    localparam logic [4:0] OP_DIV    = 5'b11000;
    localparam logic [4:0] OP_DIVU   = 5'b11010;
    localparam logic [4:0] OP_REM    = 5'b11100;
    localparam logic [4:0] OP_REMU   = 5'b11110;

    localparam int              CW       = $clog2(XLEN + 1);
    localparam logic [CW-1:0]   MUL_LAST = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0]   DIV_LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_RESP} state_e;

    state_e           state_q, state_d;
    logic [4:0]       op_q, op_d;
    logic [XLEN-1:0]  a_q, a_d;      // mul: rs1; div: dividend shifting into quotient
    logic [XLEN-1:0]  b_q, b_d;      // mul: rs2; div: divisor magnitude
    logic [XLEN-1:0]  rem_q, rem_d;  // partial remainder
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             src_q, src_d;
    logic             quo_neg_q, quo_neg_d;
    logic             rem_neg_q, rem_neg_d;
    logic             resp_valid_q, resp_valid_d;
    logic [XLEN-1:0]  resp_data_q, resp_data_d;

    logic             ready_a, ready_b, acc_a, acc_b;
    logic [4:0]       in_op;
    logic [XLEN-1:0]  in_rs1, in_rs2;
    logic [TAG_W-1:0] in_tag;
    logic             in_is_mul, in_is_div, in_sgn, in_rem;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]  mul_res, step_rem, step_quo, div_res;
    logic [XLEN:0]    rem_shift, diff;

    always_comb begin
        // Slot A is older, so it always wins; B only sees ready when A is idle.
        ready_a = rst_n & (state_q == S_IDLE) & ~flush;
        ready_b = ready_a & ~bus.req_a_valid;
        acc_a   = ready_a & bus.req_a_valid;
        acc_b   = ready_b & bus.req_b_valid;

        in_op     = acc_a ? bus.req_a_op  : bus.req_b_op;
        in_rs1    = acc_a ? bus.req_a_rs1 : bus.req_b_rs1;
        in_rs2    = acc_a ? bus.req_a_rs2 : bus.req_b_rs2;
        in_tag    = acc_a ? bus.req_a_tag : bus.req_b_tag;
        in_is_mul = (in_op == OP_MUL) || (in_op == OP_MULH) ||
                    (in_op == OP_MULHSU) || (in_op == OP_MULHU);
        in_is_div = (in_op == OP_DIV) || (in_op == OP_DIVU) ||
                    (in_op == OP_REM) || (in_op == OP_REMU);
        in_sgn    = (in_op == OP_DIV) || (in_op == OP_REM);
        in_rem    = (in_op == OP_REM) || (in_op == OP_REMU);

        // Operands are extended to 2*XLEN so the truncated product is exact for
        // every signedness mix.
        prod = {{XLEN{((op_q == OP_MULH) || (op_q == OP_MULHSU)) & a_q[XLEN-1]}}, a_q} *
               {{XLEN{(op_q == OP_MULH) & b_q[XLEN-1]}}, b_q};
        mul_res = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

        // One restoring step: shift in the next dividend bit, subtract if it fits.
        rem_shift = {rem_q, a_q[XLEN-1]};
        diff      = rem_shift - {1'b0, b_q};
        step_rem  = diff[XLEN] ? rem_shift[XLEN-1:0] : diff[XLEN-1:0];
        step_quo  = {a_q[XLEN-2:0], ~diff[XLEN]};
        if ((op_q == OP_REM) || (op_q == OP_REMU))
            div_res = rem_neg_q ? -step_rem : step_rem;
        else
            div_res = quo_neg_q ? -step_quo : step_quo;

        state_d      = state_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        rem_d        = rem_q;
        cnt_d        = cnt_q;
        tag_d        = tag_q;
        src_d        = src_q;
        quo_neg_d    = quo_neg_q;
        rem_neg_d    = rem_neg_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;

        case (state_q)
            S_IDLE: begin
                if (acc_a || acc_b) begin
                    op_d  = in_op;
                    tag_d = in_tag;
                    src_d = acc_b;
                    cnt_d = '0;
                    if (in_is_mul) begin
                        a_d     = in_rs1;
                        b_d     = in_rs2;
                        state_d = S_MUL;
                    end else if (in_is_div && (in_rs2 == '0)) begin
                        resp_data_d  = in_rem ? in_rs1 : '1;
                        resp_valid_d = 1'b1;
                        state_d      = S_RESP;
                    end else if (in_sgn && (in_rs1 == INT_MIN) && (in_rs2 == '1)) begin
                        resp_data_d  = in_rem ? '0 : INT_MIN;
                        resp_valid_d = 1'b1;
                        state_d      = S_RESP;
                    end else if (in_is_div) begin
                        a_d       = (in_sgn && in_rs1[XLEN-1]) ? -in_rs1 : in_rs1;
                        b_d       = (in_sgn && in_rs2[XLEN-1]) ? -in_rs2 : in_rs2;
                        rem_d     = '0;
                        quo_neg_d = in_sgn & (in_rs1[XLEN-1] ^ in_rs2[XLEN-1]);
                        rem_neg_d = in_sgn & in_rs1[XLEN-1];
                        state_d   = S_DIV;
                    end else begin
                        resp_data_d  = '0;
                        resp_valid_d = 1'b1;
                        state_d      = S_RESP;
                    end
                end
            end
            S_MUL: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == MUL_LAST) begin
                    resp_data_d  = mul_res;
                    resp_valid_d = 1'b1;
                    state_d      = S_RESP;
                end
            end
            S_DIV: begin
                a_d   = step_quo;
                rem_d = step_rem;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == DIV_LAST) begin
                    resp_data_d  = div_res;
                    resp_valid_d = 1'b1;
                    state_d      = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Flush drops everything, including a response that would hand off now.
        if (flush) begin
            state_d      = S_IDLE;
            resp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            rem_q        <= '0;
            cnt_q        <= '0;
            tag_q        <= '0;
            src_q        <= 1'b0;
            quo_neg_q    <= 1'b0;
            rem_neg_q    <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            rem_q        <= rem_d;
            cnt_q        <= cnt_d;
            tag_q        <= tag_d;
            src_q        <= src_d;
            quo_neg_q    <= quo_neg_d;
            rem_neg_q    <= rem_neg_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
    end

    assign bus.req_a_ready = ready_a;
    assign bus.req_b_ready = ready_b;
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_data   = resp_data_q;
    assign bus.resp_tag    = tag_q;
    assign bus.resp_src    = src_q;
    assign busy            = (state_q != S_IDLE);
    assign dbg_state       = state_q;
endmodule

// File: tb/tb_muldiv_sched.sv
// Testbench for muldiv_sched: directed corner cases, then randomized traffic,
// checked against an arithmetic reference model through an expected-response
// queue that a separate monitor drains.
module tb_muldiv_sched;
    localparam int XLEN    = 32;
    localparam int TAG_W   = 5;
    localparam int MUL_LAT = 2;
    localparam int EW      = 8 + 1 + TAG_W + XLEN;  // {latency, src, tag, data}

    localparam logic [4:0] OP_MUL    = 5'b10110;
    localparam logic [4:0] OP_MULH   = 5'b10010;
    localparam logic [4:0] OP_MULHSU = 5'b10001;
    localparam logic [4:0] OP_MULHU  = 5'b10000;
    localparam logic [4:0] OP_DIV    = 5'b11000;
    localparam logic [4:0] OP_DIVU   = 5'b11010;
    localparam logic [4:0] OP_REM    = 5'b11100;
    localparam logic [4:0] OP_REMU   = 5'b11110;

    // ---------------- clock / reset ----------------
    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       busy;
    logic [1:0] dbg_state;

    muldiv_sched_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus_if ();

    muldiv_sched #(.XLEN(XLEN), .TAG_W(TAG_W), .MUL_LAT(MUL_LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .bus       (bus_if),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;
    logic [EW-1:0] exp_q[$];
    int            acc_q[$];

    bit rr_rand = 1'b0;
    bit rr_val  = 1'b1;

    initial begin
        bus_if.resp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus_if.resp_ready = rr_rand ? ($urandom_range(0, 3) != 0) : rr_val;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [EW-1:0] model(input logic [4:0] op, input logic [31:0] rs1,
                                            input logic [31:0] rs2, input logic [TAG_W-1:0] tag,
                                            input logic src);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        logic [31:0]     d;
        int              si1, si2, lat;
        sa  = longint'($signed(rs1));
        sb  = longint'($signed(rs2));
        ua  = {32'd0, rs1};
        ub  = {32'd0, rs2};
        si1 = $signed(rs1);
        si2 = $signed(rs2);
        d   = '0;
        lat = 1;
        case (op)
            OP_MUL:    begin p = sa * sb; d = p[31:0]; lat = 1 + MUL_LAT; end
            OP_MULH:   begin p = sa * sb; d = p[63:32]; lat = 1 + MUL_LAT; end
            OP_MULHSU: begin p = sa * longint'(ub); d = p[63:32]; lat = 1 + MUL_LAT; end
            OP_MULHU:  begin p = ua * ub; d = p[63:32]; lat = 1 + MUL_LAT; end
            OP_DIV: begin
                if (rs2 == 0) d = 32'hFFFF_FFFF;
                else if (rs1 == 32'h8000_0000 && rs2 == 32'hFFFF_FFFF) d = 32'h8000_0000;
                else begin d = si1 / si2; lat = 1 + XLEN; end
            end
            OP_REM: begin
                if (rs2 == 0) d = rs1;
                else if (rs1 == 32'h8000_0000 && rs2 == 32'hFFFF_FFFF) d = 0;
                else begin d = si1 % si2; lat = 1 + XLEN; end
            end
            OP_DIVU: begin
                if (rs2 == 0) d = 32'hFFFF_FFFF;
                else begin d = rs1 / rs2; lat = 1 + XLEN; end
            end
            OP_REMU: begin
                if (rs2 == 0) d = rs1;
                else begin d = rs1 % rs2; lat = 1 + XLEN; end
            end
            default: d = 0;
        endcase
        return {8'(lat), src, tag, d};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input bit slot, input logic [4:0] op, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic [TAG_W-1:0] tag);
        if (slot) begin
            bus_if.req_b_op = op; bus_if.req_b_rs1 = rs1; bus_if.req_b_rs2 = rs2;
            bus_if.req_b_tag = tag; bus_if.req_b_valid = 1'b1;
        end else begin
            bus_if.req_a_op = op; bus_if.req_a_rs1 = rs1; bus_if.req_a_rs2 = rs2;
            bus_if.req_a_tag = tag; bus_if.req_a_valid = 1'b1;
        end
    endtask

    // Waits (bounded) for the slot's ready, records the expectation, and drops
    // valid just after the accepting edge.
    task automatic wait_accept(input bit slot, input logic [EW-1:0] e);
        bit done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (slot ? bus_if.req_b_ready : bus_if.req_a_ready) begin
                exp_q.push_back(e);
                acc_q.push_back(cyc + 1);
                done = 1'b1;
            end
        end
        if (!done) chk("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        if (slot) bus_if.req_b_valid = 1'b0;
        else      bus_if.req_a_valid = 1'b0;
    endtask

    task automatic issue(input bit slot, input logic [4:0] op, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic [TAG_W-1:0] tag);
        drive(slot, op, rs1, rs2, tag);
        wait_accept(slot, model(op, rs1, rs2, tag, slot));
    endtask

    task automatic drain();
        for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(negedge clk);
        chk("drain_timeout", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_check(input string name, input int cycles);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus_if.resp_valid) seen++;
        end
        chk(name, 64'(seen), 64'd0);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // ---------------- scoreboard monitor ----------------
    logic             held = 1'b0;
    logic             lat_done = 1'b0;
    logic [XLEN-1:0]  held_data;
    logic [TAG_W-1:0] held_tag;
    logic             held_src;

    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (!rst_n) begin
            held     = 1'b0;
            lat_done = 1'b0;
        end else if (bus_if.resp_valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_resp", 64'd1, 64'd0);
            end else begin
                e = exp_q[0];
                if (!lat_done) begin
                    chk("latency", 64'(cyc - acc_q[0] + 1), 64'(e[EW-1 -: 8]));
                    lat_done = 1'b1;
                end
                if (held)
                    chk("hold_stable", {bus_if.resp_src, bus_if.resp_tag, bus_if.resp_data},
                        {held_src, held_tag, held_data});
                chk("ready_in_resp", {bus_if.req_a_ready, bus_if.req_b_ready}, 2'b00);
                if (bus_if.resp_ready) begin
                    chk("resp_data", bus_if.resp_data, e[XLEN-1:0]);
                    chk("resp_tag", bus_if.resp_tag, e[XLEN +: TAG_W]);
                    chk("resp_src", bus_if.resp_src, e[XLEN+TAG_W]);
                    void'(exp_q.pop_front());
                    void'(acc_q.pop_front());
                    lat_done = 1'b0;
                    held     = 1'b0;
                end else begin
                    held      = 1'b1;
                    held_data = bus_if.resp_data;
                    held_tag  = bus_if.resp_tag;
                    held_src  = bus_if.resp_src;
                end
            end
        end else begin
            held = 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        logic [4:0] ops[9];
        ops = '{OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU, 5'b00111};

        bus_if.req_a_valid = 1'b0; bus_if.req_a_op = '0; bus_if.req_a_rs1 = '0;
        bus_if.req_a_rs2 = '0; bus_if.req_a_tag = '0;
        bus_if.req_b_valid = 1'b0; bus_if.req_b_op = '0; bus_if.req_b_rs1 = '0;
        bus_if.req_b_rs2 = '0; bus_if.req_b_tag = '0;

        #1;
        chk("reset_ctrl", {bus_if.resp_valid, bus_if.resp_src, busy, bus_if.req_a_ready,
                           bus_if.req_b_ready, bus_if.resp_tag}, 0);
        chk("reset_data", bus_if.resp_data, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Multiplies
        issue(0, OP_MUL, 32'd7, 32'hFFFF_FFFD, 5'd3);
        issue(0, OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4);
        issue(1, OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5);
        issue(1, OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6);
        drain();

        // Same-cycle A and B: A wins, B waits for the next IDLE
        drive(0, OP_DIV, 32'd100, 32'd7, 5'd1);
        drive(1, OP_REMU, 32'd100, 32'd7, 5'd2);
        @(negedge clk);
        chk("pair_a_ready", bus_if.req_a_ready, 1);
        chk("pair_b_ready", bus_if.req_b_ready, 0);
        exp_q.push_back(model(OP_DIV, 32'd100, 32'd7, 5'd1, 1'b0));
        acc_q.push_back(cyc + 1);
        @(posedge clk);
        #1;
        bus_if.req_a_valid = 1'b0;
        wait_accept(1, model(OP_REMU, 32'd100, 32'd7, 5'd2, 1'b1));
        drain();

        // Signed divide, divide by zero, overflow
        issue(0, OP_DIV, -32'sd100, 32'd7, 5'd7);
        issue(0, OP_REM, -32'sd100, 32'd7, 5'd8);
        issue(1, OP_DIV, 32'd5, 32'd0, 5'd9);
        issue(0, OP_REM, 32'd5, 32'd0, 5'd10);
        issue(0, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
        issue(1, OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);
        drain();

        // Writeback stalls for a while in RESP
        rr_val = 1'b0;
        @(posedge clk);
        #1;
        issue(0, 5'b00011, 32'd1, 32'd2, 5'd13);
        for (int i = 0; i < 20 && !bus_if.resp_valid; i++) @(negedge clk);
        chk("hold_resp_seen", bus_if.resp_valid, 1);
        repeat (5) @(negedge clk);
        rr_val = 1'b1;
        for (int i = 0; i < 20 && !(bus_if.resp_valid && bus_if.resp_ready); i++) @(negedge clk);
        @(posedge clk);
        #1;
        chk("idle_after_handshake", {busy, bus_if.resp_valid}, 2'b00);

        // Flush during divide iteration 10
        issue(0, OP_DIV, 32'd1000, 32'd3, 5'd14);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        void'(exp_q.pop_back());
        void'(acc_q.pop_back());
        chk("flush_idle", {busy, bus_if.resp_valid}, 2'b00);
        quiet_check("flush_no_resp", 40);

        // Reset pulse during multiply
        issue(1, OP_MUL, 32'd9, 32'd9, 5'd15);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ctrl", {bus_if.resp_valid, busy, bus_if.req_a_ready, bus_if.req_b_ready,
                             bus_if.resp_src, bus_if.resp_tag}, 0);
        chk("rst_mid_data", bus_if.resp_data, 0);
        void'(exp_q.pop_back());
        void'(acc_q.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        quiet_check("rst_no_resp", 10);

        // Randomized traffic with random writeback backpressure
        rr_rand = 1'b1;
        for (int n = 0; n < 150; n++) begin
            issue(1'($urandom_range(0, 1)), ops[$urandom_range(0, 8)], rnd_operand(),
                  rnd_operand(), TAG_W'($urandom));
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
